// File: rtl/turbo_enc_pkg.sv
// Shared constants for the turbo encoder, its serialising output block and the
// output scheduler: symbol cadence, frame geometry, FSM state codes and mode codes.
package turbo_enc_pkg;

   localparam int unsigned SYM_PERIOD   = 12;  // clocks per encoder symbol
   localparam int unsigned TAIL_SYMS    = 3;   // termination symbols per frame
   localparam int unsigned K_W          = 13;  // width of block length / symbol index
   localparam int unsigned FLUSH_CYCLES = 48;  // drain window after the last tail symbol
   localparam int unsigned PHASE_W      = $clog2(SYM_PERIOD);
   localparam int unsigned FLUSH_W      = $clog2(FLUSH_CYCLES);
   localparam int unsigned STATE_W      = 3;

   // Scheduler states
   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_DATA  = 3'd1;
   localparam logic [STATE_W-1:0] ST_TAIL  = 3'd2;
   localparam logic [STATE_W-1:0] ST_FLUSH = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

   // Output block mode encodings
   localparam logic MODE_NORMAL = 1'b0;
   localparam logic MODE_TERM   = 1'b1;

   // True in the states where the output block is being fed (validIn high)
   function automatic logic is_active(input logic [STATE_W-1:0] st);
      return (st == ST_DATA) || (st == ST_TAIL) || (st == ST_FLUSH);
   endfunction

endpackage

// File: rtl/turbo_out_scheduler_if.sv
// Control bundle between frame/MAC control and the turbo output scheduler.
//   start, blk_len, abort           : frame requests from control (master -> slave)
//   enc_step, ob_valid, ob_mode     : encoder / output block pacing (slave -> master)
//   busy, done, err, sym_cnt        : status back to control (slave -> master)
interface turbo_out_scheduler_if;
   import turbo_enc_pkg::*;

   logic           start;
   logic [K_W-1:0] blk_len;
   logic           abort;
   logic           enc_step;
   logic           ob_valid;
   logic           ob_mode;
   logic           busy;
   logic           done;
   logic           err;
   logic [K_W-1:0] sym_cnt;

   modport master (
      output start, blk_len, abort,
      input  enc_step, ob_valid, ob_mode, busy, done, err, sym_cnt
   );

   modport slave (
      input  start, blk_len, abort,
      output enc_step, ob_valid, ob_mode, busy, done, err, sym_cnt
   );

endinterface

// File: rtl/turbo_out_scheduler_sym_phase_counter.sv
// Modulo-SYM_PERIOD phase counter aligned with the output block write cadence.
//   clk, reset : clock, async active-low reset
//   en         : advance phase this cycle
//   clr        : synchronous clear to phase 0 (wins over en)
//   phase      : registered phase 0..SYM_PERIOD-1
//   first_c    : phase == 0 (decode of the register)
//   last_c     : phase == SYM_PERIOD-1 (decode of the register)
module sym_phase_counter
   import turbo_enc_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               clr,
   output logic [PHASE_W-1:0] phase,
   output logic               first_c,
   output logic               last_c
);

   assign first_c = (phase == '0);
   assign last_c  = (phase == PHASE_W'(SYM_PERIOD - 1));

   // Wrap at the end of each symbol period
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase <= '0;
      end else if (clr) begin
         phase <= '0;
      end else if (en) begin
         phase <= last_c ? '0 : phase + PHASE_W'(1);
      end
   end

endmodule

// File: rtl/turbo_out_scheduler.sv
// Frame sequencer for the turbo encoder output block: K data symbols in normal
// mode, TAIL_SYMS termination symbols, then a flush window before validIn drops.
//   clk, reset : clock, async active-low reset
//   bus        : slave side of the control bundle (start/blk_len/abort in;
//                enc_step/ob_valid/ob_mode/busy/done/err/sym_cnt out, all registered)
module turbo_out_scheduler
   import turbo_enc_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   turbo_out_scheduler_if.slave  bus
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [K_W-1:0]     sym_cnt_q, sym_cnt_d;
   logic [FLUSH_W-1:0] flush_q, flush_d;

   logic enc_step_q, enc_step_d;
   logic ob_valid_q, ob_valid_d;
   logic ob_mode_q, ob_mode_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic err_q, err_d;

   logic               phase_en, phase_clr;
   logic [PHASE_W-1:0] phase;
   logic               first_c, last_c;
   logic               abort_frame;

   // Abort only acts on a running frame; in IDLE it just masks start
   assign abort_frame = bus.abort && (state_q != ST_IDLE);
   assign phase_en    = is_active(state_q);
   assign phase_clr   = !is_active(state_q) || abort_frame;

   sym_phase_counter u_phase (
      .clk     (clk),
      .reset   (reset),
      .en      (phase_en),
      .clr     (phase_clr),
      .phase   (phase),
      .first_c (first_c),
      .last_c  (last_c)
   );

   // State and counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         k_q       <= '0;
         sym_cnt_q <= '0;
         flush_q   <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         sym_cnt_q <= sym_cnt_d;
         flush_q   <= flush_d;
      end
   end

   // Next state, counters and registered-output next values
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      sym_cnt_d  = sym_cnt_q;
      flush_d    = '0;
      enc_step_d = 1'b0;
      ob_valid_d = 1'b0;
      ob_mode_d  = MODE_NORMAL;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.abort) begin
               if (bus.blk_len != '0) begin
                  state_d   = ST_DATA;
                  k_d       = bus.blk_len;
                  sym_cnt_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (last_c) begin
               if (sym_cnt_q == k_q - K_W'(1)) begin
                  state_d   = ST_TAIL;
                  sym_cnt_d = '0;
               end else begin
                  sym_cnt_d = sym_cnt_q + K_W'(1);
               end
            end
         end
         ST_TAIL: begin
            if (last_c) begin
               if (sym_cnt_q == K_W'(TAIL_SYMS - 1)) begin
                  state_d   = ST_FLUSH;
                  sym_cnt_d = '0;
               end else begin
                  sym_cnt_d = sym_cnt_q + K_W'(1);
               end
            end
         end
         ST_FLUSH: begin
            if (flush_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
               state_d = ST_DONE;
            end else begin
               flush_d = flush_q + FLUSH_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort_frame) begin
         state_d   = ST_IDLE;
         sym_cnt_d = '0;
         flush_d   = '0;
      end

      // Outputs reflect the state being entered so they line up with it
      ob_valid_d = is_active(state_d);
      ob_mode_d  = ((state_d == ST_TAIL) || (state_d == ST_FLUSH)) ? MODE_TERM : MODE_NORMAL;
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_DONE);
      // Strobe when the next cycle is phase 0 of a data or tail symbol
      enc_step_d = ((state_d == ST_DATA) || (state_d == ST_TAIL)) &&
                   ((state_q == ST_IDLE) ? first_c : last_c);
   end

   // Output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enc_step_q <= 1'b0;
         ob_valid_q <= 1'b0;
         ob_mode_q  <= MODE_NORMAL;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         enc_step_q <= enc_step_d;
         ob_valid_q <= ob_valid_d;
         ob_mode_q  <= ob_mode_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.enc_step = enc_step_q;
   assign bus.ob_valid = ob_valid_q;
   assign bus.ob_mode  = ob_mode_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.sym_cnt  = sym_cnt_q;

endmodule

// File: tb/tb_turbo_out_scheduler.sv
// Self-checking bench for turbo_out_scheduler. Expected behaviour per cycle is
// computed from frame geometry (cycle index n after the accepting edge, K).
module tb_turbo_out_scheduler;
   import turbo_enc_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   turbo_out_scheduler_if bus();

   turbo_out_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   localparam int SP = int'(SYM_PERIOD);
   localparam int TS = int'(TAIL_SYMS);
   localparam int FC = int'(FLUSH_CYCLES);

   // ---------------- reference model ----------------
   function automatic int frame_len(input int k);
      return SP * (k + TS) + FC;
   endfunction

   // {ob_valid, ob_mode, enc_step, busy, done, err} at cycle n of a frame
   function automatic logic [5:0] model_flags(input int k, input int n);
      int   l;
      int   sym_end;
      logic v, m, s, b, d;
      l       = frame_len(k);
      sym_end = SP * (k + TS);
      v = (n < l);
      m = (n >= SP * k) && (n < l);
      s = (n < sym_end) && ((n % SP) == 0);
      b = (n <= l);
      d = (n == l);
      return {v, m, s, b, d, 1'b0};
   endfunction

   function automatic logic sym_valid(input int k, input int n);
      return n < SP * (k + TS);
   endfunction

   function automatic int model_sym(input int k, input int n);
      return (n < SP * k) ? n / SP : (n - SP * k) / SP;
   endfunction

   function automatic logic [5:0] obs();
      return {bus.ob_valid, bus.ob_mode, bus.enc_step, bus.busy, bus.done, bus.err};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present start for one edge; returns in cycle n=0 of the frame
   task automatic start_frame(input int k);
      bus.blk_len = K_W'(k);
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset       = 1'b0;
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.blk_len = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs() !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=%b", obs(), 6'b0);
      end
      checks++;
      if (bus.sym_cnt !== '0) begin
         failures++;
         $display("FAIL reset_sym got=%0d exp=0", bus.sym_cnt);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (obs() !== 6'b0) begin
         failures++;
         $display("FAIL post_reset_idle got=%b exp=%b", obs(), 6'b0);
      end
   endtask

   task automatic test_frame_k4();
      int k, l, steps, vcnt, mode_first, done_at;
      logic [5:0] e;
      k = 4; l = frame_len(k);
      steps = 0; vcnt = 0; mode_first = -1; done_at = -1;
      start_frame(k);
      for (int n = 0; n <= l + 1; n++) begin
         e = model_flags(k, n);
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL k4_flags n=%0d got=%b exp=%b", n, obs(), e);
         end
         if (sym_valid(k, n)) begin
            checks++;
            if (bus.sym_cnt !== K_W'(model_sym(k, n))) begin
               failures++;
               $display("FAIL k4_sym n=%0d got=%0d exp=%0d", n, bus.sym_cnt, model_sym(k, n));
            end
         end
         steps += int'(bus.enc_step);
         vcnt  += int'(bus.ob_valid);
         if (bus.ob_mode && mode_first < 0) mode_first = n;
         if (bus.done) done_at = n;
         tick();
      end
      checks++;
      if (steps !== 7) begin
         failures++;
         $display("FAIL k4_step_count got=%0d exp=7", steps);
      end
      checks++;
      if (vcnt !== 132) begin
         failures++;
         $display("FAIL k4_valid_len got=%0d exp=132", vcnt);
      end
      checks++;
      if (mode_first !== 48) begin
         failures++;
         $display("FAIL k4_mode_rise got=%0d exp=48", mode_first);
      end
      checks++;
      if (done_at !== 132) begin
         failures++;
         $display("FAIL k4_done_at got=%0d exp=132", done_at);
      end
   endtask

   task automatic test_zero_len();
      bus.blk_len = '0;
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
      checks++;
      if (obs() !== 6'b000001) begin
         failures++;
         $display("FAIL zero_len_err got=%b exp=%b", obs(), 6'b000001);
      end
      tick();
      checks++;
      if (obs() !== 6'b0) begin
         failures++;
         $display("FAIL zero_len_after got=%b exp=%b", obs(), 6'b0);
      end
   endtask

   task automatic test_abort();
      int k, l;
      logic [5:0] e;
      k = 3;
      start_frame(k);
      for (int n = 0; n <= 30; n++) begin
         e = model_flags(k, n);
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL abort_pre n=%0d got=%b exp=%b", n, obs(), e);
         end
         if (n < 30) tick();
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      checks++;
      if (obs() !== 6'b0) begin
         failures++;
         $display("FAIL abort_flags got=%b exp=%b", obs(), 6'b0);
      end
      checks++;
      if (bus.sym_cnt !== '0) begin
         failures++;
         $display("FAIL abort_sym got=%0d exp=0", bus.sym_cnt);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({bus.done, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL abort_quiet i=%0d got=%b exp=00", i, {bus.done, bus.busy});
         end
      end
      // Abort in IDLE masks a simultaneous start
      bus.abort = 1'b1;
      start_frame(2);
      bus.abort = 1'b0;
      checks++;
      if (obs() !== 6'b0) begin
         failures++;
         $display("FAIL abort_beats_start got=%b exp=%b", obs(), 6'b0);
      end
      k = 1; l = frame_len(k);
      start_frame(k);
      for (int n = 0; n <= l + 1; n++) begin
         e = model_flags(k, n);
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL abort_k1_flags n=%0d got=%b exp=%b", n, obs(), e);
         end
         tick();
      end
   endtask

   task automatic test_ignore_start();
      int k, l, steps, vcnt;
      logic [5:0] e;
      k = 2; l = frame_len(k); steps = 0; vcnt = 0;
      start_frame(k);
      for (int n = 0; n <= l + 1; n++) begin
         if (n == 20) begin
            bus.start   = 1'b1;
            bus.blk_len = K_W'(9);
         end
         if (n == 25) bus.start = 1'b0;
         e = model_flags(k, n);
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL ignore_flags n=%0d got=%b exp=%b", n, obs(), e);
         end
         if (sym_valid(k, n)) begin
            checks++;
            if (bus.sym_cnt !== K_W'(model_sym(k, n))) begin
               failures++;
               $display("FAIL ignore_sym n=%0d got=%0d exp=%0d", n, bus.sym_cnt, model_sym(k, n));
            end
         end
         steps += int'(bus.enc_step);
         vcnt  += int'(bus.ob_valid);
         tick();
      end
      checks++;
      if (vcnt !== 108 || steps !== 5) begin
         failures++;
         $display("FAIL ignore_totals got=%0d/%0d exp=108/5", vcnt, steps);
      end
   endtask

   task automatic test_async_reset();
      int k, l, stop;
      logic [5:0] e;
      k = int'($urandom_range(1, 4));
      stop = SP * k + 5;
      start_frame(k);
      for (int n = 0; n <= stop; n++) begin
         e = model_flags(k, n);
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL areset_pre k=%0d n=%0d got=%b exp=%b", k, n, obs(), e);
         end
         if (n < stop) tick();
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.ob_valid, bus.ob_mode, bus.busy} !== 3'b000) begin
         failures++;
         $display("FAIL areset_clear got=%b exp=000", {bus.ob_valid, bus.ob_mode, bus.busy});
      end
      #2;
      bus.blk_len = K_W'(1);
      bus.start   = 1'b1;
      reset       = 1'b1;
      tick();
      bus.start   = 1'b0;
      k = 1; l = frame_len(k);
      for (int n = 0; n <= l + 1; n++) begin
         e = model_flags(k, n);
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL areset_k1_flags n=%0d got=%b exp=%b", n, obs(), e);
         end
         tick();
      end
   endtask

   task automatic test_random_frames();
      int k, l;
      logic [5:0] e;
      for (int f = 0; f < 6; f++) begin
         k = int'($urandom_range(1, 8));
         l = frame_len(k);
         repeat ($urandom_range(0, 3)) tick();
         start_frame(k);
         for (int n = 0; n <= l + 1; n++) begin
            // Random start/blk_len noise while busy must not disturb the frame
            if (n < l - 2) begin
               bus.start   = 1'($urandom_range(0, 1));
               bus.blk_len = K_W'($urandom_range(0, 8191));
            end else begin
               bus.start = 1'b0;
            end
            e = model_flags(k, n);
            checks++;
            if (obs() !== e) begin
               failures++;
               $display("FAIL rand_flags f=%0d k=%0d n=%0d got=%b exp=%b", f, k, n, obs(), e);
            end
            if (sym_valid(k, n)) begin
               checks++;
               if (bus.sym_cnt !== K_W'(model_sym(k, n))) begin
                  failures++;
                  $display("FAIL rand_sym f=%0d n=%0d got=%0d exp=%0d", f, n, bus.sym_cnt, model_sym(k, n));
               end
            end
            tick();
         end
      end
   endtask

   task automatic test_back_to_back();
      int k, l, idx, gap;
      logic [5:0] e;
      k = int'($urandom_range(1, 4));
      l = frame_len(k);
      gap = 0;
      bus.blk_len = K_W'(k);
      bus.start   = 1'b1;
      tick();
      for (int g = 0; g <= 2 * l + 3; g++) begin
         if (g == l + 5) bus.start = 1'b0;
         // Second frame is accepted on the edge leaving the IDLE cycle after DONE
         idx = (g <= l + 1) ? g : g - (l + 2);
         e = model_flags(k, idx);
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL b2b_flags k=%0d g=%0d got=%b exp=%b", k, g, obs(), e);
         end
         if (g > 0 && g < l + 2 && !bus.ob_valid) gap++;
         tick();
      end
      checks++;
      if (gap !== 2) begin
         failures++;
         $display("FAIL b2b_gap got=%0d exp=2", gap);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_frame_k4();
      test_zero_len();
      test_abort();
      test_ignore_start();
      test_async_reset();
      test_random_frames();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
